// File: rtl/harvos_lsu_pkg.sv
// Shared types for the harvos load/store unit: access size codes, response
// causes, FSM states and the size-to-lane-width helper.
package harvos_lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_MISALIGN  = 2'b01,
        CAUSE_BUS_FAULT = 2'b10,
        CAUSE_TIMEOUT   = 2'b11
    } lsu_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10
    } lsu_width_e;

    // Bit 2 of the size code only selects zero-extension, so width comes from [1:0].
    function automatic lsu_width_e size_width(input logic [1:0] size);
        case (size)
            2'b00:   return WIDTH_BYTE;
            2'b01:   return WIDTH_HALF;
            default: return WIDTH_WORD;
        endcase
    endfunction

endpackage

// File: rtl/harvos_dmem_if.sv
// Data-memory bus between the LSU (master) and the memory slave.
interface harvos_dmem_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, done, fault
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, done, fault
    );
endinterface

// File: rtl/harvos_lsu_align.sv
// Combinational lane logic: byte enables, write-data replication, alignment
// check for the request side and lane extract/extend for returned load data.
module harvos_lsu_align
    import harvos_lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] ld_data_o
);

    lsu_width_e  req_width;
    lsu_width_e  ld_width;
    logic [31:0] ld_shifted;
    logic        ld_signed;

    assign req_width  = size_width(req_size_i);
    assign ld_width   = size_width(ld_size_i[1:0]);
    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    assign ld_signed  = ~ld_size_i[2];

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = req_wdata_i;
        misaligned_o = 1'b0;
        case (req_width)
            WIDTH_BYTE: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            WIDTH_HALF: begin
                be_o         = 4'b0011 << req_off_i;
                wdata_o      = {2{req_wdata_i[15:0]}};
                misaligned_o = req_off_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                misaligned_o = |req_off_i;
            end
        endcase
    end

    // A word access is always at offset 0, so the shifted value is the raw word.
    always_comb begin
        case (ld_width)
            WIDTH_BYTE: ld_data_o = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            WIDTH_HALF: ld_data_o = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default:    ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/harvos_lsu.sv
// harvos load/store unit: one-at-a-time FSM driving harvos_dmem_if.master.
// Optional bus watchdog enabled by defining HARVOS_LSU_TIMEOUT_EN.
module harvos_lsu
    import harvos_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic          op_store,
    input  logic [2:0]    op_size,
    input  logic [31:0]   op_addr,
    input  logic [31:0]   op_wdata,
    input  logic [4:0]    op_rd,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic [4:0]    rsp_rd,
    output logic          rsp_exc,
    output logic [1:0]    rsp_cause,
    harvos_dmem_if.master dmem
);

    lsu_state_e  state_q, state_d;
    lsu_cause_e  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q;
    logic        store_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        req_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        misaligned;
    logic [31:0] ld_data;
    logic        accept;
    logic        timeout_hit;

    assign accept = op_valid && ready_q;

    harvos_lsu_align u_align (
        .req_size_i   (op_size[1:0]),
        .req_off_i    (op_addr[1:0]),
        .req_wdata_i  (op_wdata),
        .ld_size_i    (size_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (dmem.rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (misaligned),
        .ld_data_o    (ld_data)
    );

`ifdef HARVOS_LSU_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_q;

    // Held at zero outside BUS, so it is already clear on the first BUS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != ST_BUS) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_q + 8'd1;
        end
    end

    assign timeout_hit = (state_q == ST_BUS) && (wd_q == WD_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    if (misaligned) begin
                        state_d = ST_RESP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = ST_BUS;
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            ST_BUS: begin
                if (dmem.fault) begin
                    state_d = ST_RESP;
                    cause_d = CAUSE_BUS_FAULT;
                end else if (dmem.done) begin
                    state_d = ST_RESP;
                    rdata_d = store_q ? 32'd0 : ld_data;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ready and req are registered from the next state so neither has a
    // combinational path from the bus inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            rdata_q <= '0;
            ready_q <= 1'b0;
            store_q <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
            ready_q <= (state_d == ST_IDLE);
            req_q   <= (state_d == ST_BUS);
            if (accept) begin
                store_q <= op_store;
                size_q  <= op_size;
                off_q   <= op_addr[1:0];
                rd_q    <= op_rd;
                we_q    <= op_store;
                be_q    <= lane_be;
                addr_q  <= {op_addr[31:2], 2'b00};
                wdata_q <= lane_wdata;
            end
        end
    end

    assign op_ready   = ready_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q : 32'd0;
    assign rsp_rd     = rsp_valid ? rd_q : 5'd0;
    assign rsp_exc    = rsp_valid && (cause_q != CAUSE_NONE);
    assign rsp_cause  = rsp_valid ? cause_q : CAUSE_NONE;

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_harvos_lsu.sv
// Bench for harvos_lsu: vector table plus hand sequences for reset, stray
// bus strobes and the watchdog (HARVOS_LSU_TIMEOUT_EN) / indefinite wait.
module tb_harvos_lsu;
    import harvos_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    logic [2:0]  op_size;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_exc;
    logic [1:0]  rsp_cause;

    harvos_dmem_if dmem_bus ();

    harvos_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_store  (op_store),
        .op_size   (op_size),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .op_rd     (op_rd),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_rd    (rsp_rd),
        .rsp_exc   (rsp_exc),
        .rsp_cause (rsp_cause),
        .dmem      (dmem_bus)
    );

    typedef struct {
        bit          store;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          waits;
        bit          done;
        bit          fault;
        logic [31:0] slv_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_cause;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every response pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rd=%0d, expected no response", rsp_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
                chk("rsp_cause", 32'(rsp_cause), 32'(e.cause));
                chk("rsp_exc", 32'(rsp_exc), 32'(e.cause != 2'b00));
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (op_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_op", 32'(op_ready), 32'd1);
    endtask

    task automatic drive_op(input bit store, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        op_valid = 1'b1;
        op_store = store;
        op_size  = size;
        op_addr  = addr;
        op_wdata = wdata;
        op_rd    = rd;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_ready();
        sb.push_back('{v.exp_rdata, v.rd, v.exp_cause});
        drive_op(v.store, v.size, v.addr, v.wdata, v.rd);
        if (v.exp_cause == 2'b01) begin
            chk("misalign_no_req", 32'(dmem_bus.req), 32'd0);
            chk("misalign_rsp_cycle1", 32'(rsp_valid), 32'd1);
        end else begin
            chk("req_cycle1", 32'(dmem_bus.req), 32'd1);
            chk("bus_addr", dmem_bus.addr, v.exp_addr);
            chk("bus_be", 32'(dmem_bus.be), 32'(v.exp_be));
            chk("bus_we", 32'(dmem_bus.we), 32'(v.store));
            chk("bus_wdata", dmem_bus.wdata, v.exp_wdata);
            for (int w = 0; w < v.waits; w++) begin
                @(posedge clk); #1;
                chk("req_held", 32'(dmem_bus.req), 32'd1);
                chk("addr_held", dmem_bus.addr, v.exp_addr);
                chk("no_early_rsp", 32'(rsp_valid), 32'd0);
            end
            dmem_bus.done  = v.done;
            dmem_bus.fault = v.fault;
            dmem_bus.rdata = v.slv_rdata;
            @(posedge clk); #1;
            dmem_bus.done  = 1'b0;
            dmem_bus.fault = 1'b0;
            dmem_bus.rdata = $urandom;
            chk("req_drop", 32'(dmem_bus.req), 32'd0);
            chk("rsp_cycle", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1;
        chk("ready_after", 32'(op_ready), 32'd1);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        $display("vec %0d: st=%0d size=%b addr=%h -> rdata=%h cause=%0d", idx, v.store, v.size,
                 v.addr, v.exp_rdata, v.exp_cause);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //          st  size    addr          wdata         rd  w  dn fl slv_rdata     be       bus_addr      bus_wdata     rsp_rdata     cause
        vecs[0]  = '{0, 3'b000, 32'h0000_1003, 32'h0,        5'd1, 0, 1, 0, 32'h80FF_0000, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 2'b00};
        vecs[1]  = '{1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd2, 1, 1, 0, 32'h0,        4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 32'h0,        2'b00};
        vecs[2]  = '{0, 3'b010, 32'h0000_3001, 32'h0,        5'd3, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        2'b01};
        vecs[3]  = '{0, 3'b101, 32'h0000_4000, 32'h0,        5'd4, 3, 1, 1, 32'h1234_ABCD, 4'b0011, 32'h0000_4000, 32'h0,        32'h0,        2'b10};
        vecs[4]  = '{0, 3'b001, 32'h0000_5002, 32'h0,        5'd5, 2, 1, 0, 32'h8001_7FFF, 4'b1100, 32'h0000_5000, 32'h0,        32'hFFFF_8001, 2'b00};
        vecs[5]  = '{0, 3'b100, 32'h0000_6001, 32'h0,        5'd6, 0, 1, 0, 32'h0000_9A00, 4'b0010, 32'h0000_6000, 32'h0,        32'h0000_009A, 2'b00};
        vecs[6]  = '{1, 3'b000, 32'h0000_7001, 32'h1234_56A5, 5'd7, 0, 1, 0, 32'h0,        4'b0010, 32'h0000_7000, 32'hA5A5_A5A5, 32'h0,        2'b00};
        vecs[7]  = '{1, 3'b010, 32'h0000_8000, 32'hDEAD_BEEF, 5'd8, 1, 1, 0, 32'h0,        4'b1111, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,        2'b00};
        vecs[8]  = '{0, 3'b010, 32'h0000_9000, 32'h0,        5'd9, 0, 1, 0, 32'hCAFE_F00D, 4'b1111, 32'h0000_9000, 32'h0,        32'hCAFE_F00D, 2'b00};
        vecs[9]  = '{1, 3'b001, 32'h0000_A001, 32'h0000_1111, 5'd10, 0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        32'h0,        2'b01};
        vecs[10] = '{0, 3'b101, 32'h0000_B002, 32'h0,        5'd11, 1, 1, 0, 32'hFEDC_0000, 4'b1100, 32'h0000_B000, 32'h0,       32'h0000_FEDC, 2'b00};
        vecs[11] = '{1, 3'b010, 32'h0000_C004, 32'h5555_AAAA, 5'd12, 0, 0, 1, 32'h0,       4'b1111, 32'h0000_C004, 32'h5555_AAAA, 32'h0,       2'b10};
        vecs[12] = '{0, 3'b000, 32'h0000_D000, 32'h0,        5'd13, 0, 1, 0, 32'h0000_007F, 4'b0001, 32'h0000_D000, 32'h0,       32'h0000_007F, 2'b00};
        vecs[13] = '{1, 3'b010, 32'h0000_E002, 32'h0,        5'd14, 0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        32'h0,        2'b01};

        rst_n = 1'b0;
        op_valid = 1'b0; op_store = 1'b0; op_size = 3'b000;
        op_addr = '0; op_wdata = '0; op_rd = '0;
        dmem_bus.done = 1'b0; dmem_bus.fault = 1'b0; dmem_bus.rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_op_ready", 32'(op_ready), 32'd0);
        chk("reset_req", 32'(dmem_bus.req), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_bus_be", 32'(dmem_bus.be), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(op_ready), 32'd1);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Stray done/fault while idle must not start anything.
        dmem_bus.done = 1'b1; dmem_bus.fault = 1'b1;
        @(posedge clk); #1;
        dmem_bus.done = 1'b0; dmem_bus.fault = 1'b0;
        chk("stray_ready", 32'(op_ready), 32'd1);
        chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
        chk("stray_no_req", 32'(dmem_bus.req), 32'd0);
        $display("seq stray strobes in IDLE");

        // Reset while a load is on the bus: no response, then a clean restart.
        wait_ready();
        drive_op(1'b0, 3'b000, 32'h0000_1100, 32'h0, 5'd20);
        chk("rstbus_req_cycle1", 32'(dmem_bus.req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstbus_req", 32'(dmem_bus.req), 32'd0);
        chk("rstbus_addr", dmem_bus.addr, 32'd0);
        chk("rstbus_be", 32'(dmem_bus.be), 32'd0);
        chk("rstbus_ready", 32'(op_ready), 32'd0);
        chk("rstbus_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstbus_ready_back", 32'(op_ready), 32'd1);
        chk("rstbus_no_rsp", 32'(rsp_valid), 32'd0);
        $display("seq reset during BUS");
        run_vec('{0, 3'b100, 32'h0000_1101, 32'h0, 5'd21, 0, 1, 0, 32'h0000_F000, 4'b0010,
                  32'h0000_1100, 32'h0, 32'h0000_00F0, 2'b00}, 100);

`ifdef HARVOS_LSU_TIMEOUT_EN
        begin
            int hi = 0;
            wait_ready();
            sb.push_back('{32'h0, 5'd22, 2'b11});
            drive_op(1'b0, 3'b010, 32'h0000_F000, 32'h0, 5'd22);
            for (int c = 0; c < 4; c++) begin
                if (dmem_bus.req === 1'b1) hi++;
                @(posedge clk); #1;
            end
            chk("timeout_req_cycles", 32'(hi), 32'd4);
            chk("timeout_req_drop", 32'(dmem_bus.req), 32'd0);
            chk("timeout_rsp", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
            chk("timeout_ready", 32'(op_ready), 32'd1);
            @(posedge clk); #1;
            dmem_bus.done = 1'b1; dmem_bus.rdata = 32'h1357_9BDF;
            @(posedge clk); #1;
            dmem_bus.done = 1'b0;
            chk("late_done_no_rsp", 32'(rsp_valid), 32'd0);
            chk("late_done_ready", 32'(op_ready), 32'd1);
            chk("timeout_sb_drained", 32'(sb.size()), 32'd0);
            sb.delete();
            $display("seq watchdog timeout with late done");
        end
`else
        begin
            int hi = 0;
            wait_ready();
            sb.push_back('{32'h0BAD_F00D, 5'd22, 2'b00});
            drive_op(1'b0, 3'b010, 32'h0000_F000, 32'h0, 5'd22);
            for (int c = 0; c < 20; c++) begin
                if (dmem_bus.req === 1'b1 && rsp_valid === 1'b0) hi++;
                @(posedge clk); #1;
            end
            chk("nowd_req_held", 32'(hi), 32'd20);
            dmem_bus.done = 1'b1; dmem_bus.rdata = 32'h0BAD_F00D;
            @(posedge clk); #1;
            dmem_bus.done = 1'b0;
            chk("nowd_rsp", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
            chk("nowd_ready", 32'(op_ready), 32'd1);
            chk("nowd_sb_drained", 32'(sb.size()), 32'd0);
            sb.delete();
            $display("seq long wait without watchdog");
        end
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
